// File: rtl/ss_map_pkg.sv
// rtl/ss_map_pkg.sv - shared constants and types for the world-map sequencer
package ss_map_pkg;

    localparam int DEF_NUM_MAPS = 4;
    localparam int DEF_MAP_W    = 2;
    localparam int DEF_LOC_W    = 8;
    localparam int DEF_DATA_W   = 2;

    localparam logic [7:0] DEF_RIGHT_EDGE  = 8'h7C;
    localparam logic [7:0] DEF_LEFT_EDGE   = 8'h00;
    localparam logic [7:0] DEF_ENTRY_LEFT  = 8'h01;
    localparam logic [7:0] DEF_ENTRY_RIGHT = 8'h7B;

    typedef logic [1:0] state_t;
    localparam state_t S_PLAY  = 2'd0;
    localparam state_t S_TP    = 2'd1;
    localparam state_t S_REARM = 2'd2;

    typedef logic [DEF_MAP_W-1:0] map_idx_t;

endpackage

// File: rtl/ss_map_data_mux.sv
// rtl/ss_map_data_mux.sv - registered N:1 selector over packed per-map ROM data
module ss_map_data_mux
    import ss_map_pkg::*;
#(
    parameter int NUM_MAPS = DEF_NUM_MAPS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAP_W    = DEF_MAP_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [MAP_W-1:0]           sel,
    input  logic [NUM_MAPS*DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0]          q
);

    logic [DATA_W-1:0] picked;

    // Out-of-range selects read as zero rather than aliasing another map.
    always_comb begin
        picked = '0;
        for (int i = 0; i < NUM_MAPS; i++) begin
            if (sel == MAP_W'(i)) begin
                picked = rom_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= picked;
        end
    end

endmodule

// File: rtl/ss_map_sequencer.sv
// rtl/ss_map_sequencer.sv - edge-driven map switching with teleport handshake and ROM muxing
module ss_map_sequencer
    import ss_map_pkg::*;
#(
    parameter int               NUM_MAPS    = DEF_NUM_MAPS,
    parameter int               MAP_W       = DEF_MAP_W,
    parameter int               LOC_W       = DEF_LOC_W,
    parameter int               DATA_W      = DEF_DATA_W,
    parameter logic [LOC_W-1:0] RIGHT_EDGE  = DEF_RIGHT_EDGE,
    parameter logic [LOC_W-1:0] LEFT_EDGE   = DEF_LEFT_EDGE,
    parameter logic [LOC_W-1:0] ENTRY_LEFT  = DEF_ENTRY_LEFT,
    parameter logic [LOC_W-1:0] ENTRY_RIGHT = DEF_ENTRY_RIGHT,
    parameter int               START_MAP   = 0,
    parameter bit               WRAP        = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [LOC_W-1:0]           loc_x,
    input  logic                       loc_valid,
    input  logic                       force_load,
    input  logic [MAP_W-1:0]           force_map,
    input  logic                       tp_ack,
    input  logic [NUM_MAPS*DATA_W-1:0] wm_data_in,
    input  logic [NUM_MAPS*DATA_W-1:0] px_data_in,
    output logic [DATA_W-1:0]          worldmap_data,
    output logic [DATA_W-1:0]          world_pixel,
    output logic [MAP_W-1:0]           current_map,
    output logic                       tp_valid,
    output logic [LOC_W-1:0]           tp_x,
    output logic                       switch_busy
);

    localparam logic [MAP_W-1:0] LAST_MAP  = MAP_W'(NUM_MAPS - 1);
    localparam logic [MAP_W-1:0] FIRST_MAP = '0;

    state_t           state;
    logic             at_right;
    logic             at_left;
    logic             interior;
    logic [MAP_W-1:0] next_map;
    logic [MAP_W-1:0] prev_map;
    logic [MAP_W-1:0] forced_map;

    assign at_right = (loc_x >= RIGHT_EDGE) && ((current_map != LAST_MAP) || WRAP);
    assign at_left  = (loc_x <= LEFT_EDGE) && ((current_map != FIRST_MAP) || WRAP);
    assign interior = (loc_x > LEFT_EDGE) && (loc_x < RIGHT_EDGE);

    assign next_map = (current_map == LAST_MAP) ? FIRST_MAP : current_map + 1'b1;
    assign prev_map = (current_map == FIRST_MAP) ? LAST_MAP : current_map - 1'b1;

    // Widened compare so the clamp stays meaningful when 2**MAP_W == NUM_MAPS.
    assign forced_map = ({1'b0, force_map} > {1'b0, LAST_MAP}) ? LAST_MAP : force_map;

    assign switch_busy = (state != S_PLAY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_REARM;
            current_map <= MAP_W'(START_MAP);
            tp_valid    <= 1'b0;
            tp_x        <= '0;
        end else if (force_load) begin
            current_map <= forced_map;
            tp_valid    <= 1'b0;
            state       <= S_REARM;
        end else begin
            case (state)
                S_PLAY: begin
                    if (loc_valid && at_right) begin
                        current_map <= next_map;
                        tp_x        <= ENTRY_LEFT;
                        tp_valid    <= 1'b1;
                        state       <= S_TP;
                    end else if (loc_valid && at_left) begin
                        current_map <= prev_map;
                        tp_x        <= ENTRY_RIGHT;
                        tp_valid    <= 1'b1;
                        state       <= S_TP;
                    end
                end
                S_TP: begin
                    if (tp_ack && tp_valid) begin
                        tp_valid <= 1'b0;
                        state    <= S_REARM;
                    end
                end
                // The player must leave the edge zone before another switch can fire.
                S_REARM: begin
                    if (loc_valid && interior) begin
                        state <= S_PLAY;
                    end
                end
                default: state <= S_REARM;
            endcase
        end
    end

    ss_map_data_mux #(.NUM_MAPS(NUM_MAPS), .DATA_W(DATA_W), .MAP_W(MAP_W)) u_wm_mux (
        .clk      (clk),
        .reset    (reset),
        .sel      (current_map),
        .rom_data (wm_data_in),
        .q        (worldmap_data)
    );

    ss_map_data_mux #(.NUM_MAPS(NUM_MAPS), .DATA_W(DATA_W), .MAP_W(MAP_W)) u_px_mux (
        .clk      (clk),
        .reset    (reset),
        .sel      (current_map),
        .rom_data (px_data_in),
        .q        (world_pixel)
    );

endmodule

// File: tb/tb_ss_map_sequencer.sv
// tb/tb_ss_map_sequencer.sv - directed bench: clamped 3-bit-index instance and wrapping instance
module tb_ss_map_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] loc_x = 8'h40;
    logic       loc_valid = 1'b0;
    logic       force_load = 1'b0;
    logic [2:0] force_map = 3'd0;
    logic       tp_ack = 1'b0;
    logic [7:0] wm_data = 8'hE4;
    logic [7:0] px_data = 8'h1B;

    logic [1:0] a_wm, a_px, b_wm, b_px;
    logic [2:0] a_map;
    logic [1:0] b_map;
    logic       a_tpv, b_tpv, a_busy, b_busy;
    logic [7:0] a_tpx, b_tpx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ss_map_sequencer #(.MAP_W(3), .WRAP(1'b0)) dut_a (
        .clk(clk), .reset(reset), .loc_x(loc_x), .loc_valid(loc_valid),
        .force_load(force_load), .force_map(force_map), .tp_ack(tp_ack),
        .wm_data_in(wm_data), .px_data_in(px_data),
        .worldmap_data(a_wm), .world_pixel(a_px), .current_map(a_map),
        .tp_valid(a_tpv), .tp_x(a_tpx), .switch_busy(a_busy)
    );

    ss_map_sequencer #(.WRAP(1'b1)) dut_b (
        .clk(clk), .reset(reset), .loc_x(loc_x), .loc_valid(loc_valid),
        .force_load(force_load), .force_map(force_map[1:0]), .tp_ack(tp_ack),
        .wm_data_in(wm_data), .px_data_in(px_data),
        .worldmap_data(b_wm), .world_pixel(b_px), .current_map(b_map),
        .tp_valid(b_tpv), .tp_x(b_tpx), .switch_busy(b_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        checks++; if (a_map !== 3'd0) begin errors++; $display("FAIL rst_map: got %0d expected 0", a_map); end
        checks++; if (a_tpv !== 1'b0) begin errors++; $display("FAIL rst_tpv: got %0b expected 0", a_tpv); end
        checks++; if (a_tpx !== 8'h00) begin errors++; $display("FAIL rst_tpx: got %0h expected 00", a_tpx); end
        checks++; if ({a_wm, a_px} !== 4'b0000) begin errors++; $display("FAIL rst_data: got %0b expected 0000", {a_wm, a_px}); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %0b expected 1", a_busy); end
        reset = 1'b1;
        step();
        checks++; if (a_px !== 2'b11) begin errors++; $display("FAIL rst_first_px: got %0b expected 11", a_px); end
        loc_x = 8'h40; loc_valid = 1'b1;
        step();
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_to_play: got %0b expected 0", a_busy); end
    endtask

    task automatic test_forward();
        loc_x = 8'h7C;
        step();
        checks++; if (a_map !== 3'd1) begin errors++; $display("FAIL fwd_map: got %0d expected 1", a_map); end
        checks++; if (a_tpv !== 1'b1) begin errors++; $display("FAIL fwd_tpv: got %0b expected 1", a_tpv); end
        checks++; if (a_tpx !== 8'h01) begin errors++; $display("FAIL fwd_tpx: got %0h expected 01", a_tpx); end
        checks++; if (a_wm !== 2'b00) begin errors++; $display("FAIL fwd_wm_lag: got %0b expected 00", a_wm); end
        repeat (5) step();
        checks++; if (a_map !== 3'd1 || a_tpv !== 1'b1) begin errors++; $display("FAIL fwd_hold: got map %0d tpv %0b expected 1 1", a_map, a_tpv); end
        checks++; if ({a_wm, a_px} !== 4'b0110) begin errors++; $display("FAIL fwd_data: got %0b expected 0110", {a_wm, a_px}); end
        tp_ack = 1'b1;
        step();
        tp_ack = 1'b0;
        checks++; if (a_tpv !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL fwd_ack: got tpv %0b busy %0b expected 0 1", a_tpv, a_busy); end
        step();
        checks++; if (a_map !== 3'd1 || a_busy !== 1'b1) begin errors++; $display("FAIL fwd_rearm_hold: got map %0d busy %0b expected 1 1", a_map, a_busy); end
        loc_x = 8'h01;
        step();
        loc_x = 8'h02;
        step();
        checks++; if (a_busy !== 1'b0 || a_map !== 3'd1) begin errors++; $display("FAIL fwd_replay: got busy %0b map %0d expected 0 1", a_busy, a_map); end
    endtask

    task automatic test_backward_wrap();
        loc_x = 8'h00;
        step();
        checks++; if (a_map !== 3'd0 || a_tpx !== 8'h7B || a_tpv !== 1'b1) begin errors++; $display("FAIL bwd_a: got map %0d tpx %0h tpv %0b expected 0 7b 1", a_map, a_tpx, a_tpv); end
        checks++; if (b_map !== 2'd0 || b_tpx !== 8'h7B) begin errors++; $display("FAIL bwd_b: got map %0d tpx %0h expected 0 7b", b_map, b_tpx); end
        tp_ack = 1'b1;
        step();
        tp_ack = 1'b0;
        loc_x = 8'h40;
        step();
        loc_x = 8'h00;
        step();
        checks++; if (a_map !== 3'd0 || a_tpv !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL clamp_left: got map %0d tpv %0b busy %0b expected 0 0 0", a_map, a_tpv, a_busy); end
        checks++; if (b_map !== 2'd3 || b_tpv !== 1'b1 || b_tpx !== 8'h7B) begin errors++; $display("FAIL wrap_left: got map %0d tpv %0b tpx %0h expected 3 1 7b", b_map, b_tpv, b_tpx); end
        loc_x = 8'h40; tp_ack = 1'b1;
        step();
        tp_ack = 1'b0;
    endtask

    task automatic test_force();
        loc_valid = 1'b0;
        wm_data = 8'hC0; px_data = 8'hC0;
        force_load = 1'b1; force_map = 3'd3;
        step();
        force_load = 1'b0;
        checks++; if (a_map !== 3'd3 || b_map !== 2'd3 || a_tpv !== 1'b0) begin errors++; $display("FAIL force3: got a %0d b %0d tpv %0b expected 3 3 0", a_map, b_map, a_tpv); end
        checks++; if (a_wm !== 2'b00) begin errors++; $display("FAIL force3_lag: got %0b expected 00", a_wm); end
        step();
        checks++; if ({a_wm, a_px, b_wm, b_px} !== 8'hFF) begin errors++; $display("FAIL force3_data: got %0h expected ff", {a_wm, a_px, b_wm, b_px}); end
        force_load = 1'b1; force_map = 3'd2;
        step();
        checks++; if (a_map !== 3'd2) begin errors++; $display("FAIL force2: got %0d expected 2", a_map); end
        force_map = 3'd7;
        step();
        force_load = 1'b0;
        checks++; if (a_map !== 3'd3 || b_map !== 2'd3) begin errors++; $display("FAIL force_clamp: got a %0d b %0d expected 3 3", a_map, b_map); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL force_rearm: got %0b expected 1", a_busy); end
    endtask

    task automatic test_force_vs_ack();
        loc_valid = 1'b1; loc_x = 8'h40;
        step();
        loc_x = 8'h00;
        step();
        checks++; if (a_map !== 3'd2 || a_tpv !== 1'b1) begin errors++; $display("FAIL fva_setup: got map %0d tpv %0b expected 2 1", a_map, a_tpv); end
        force_load = 1'b1; force_map = 3'd1; tp_ack = 1'b1;
        step();
        force_load = 1'b0; tp_ack = 1'b0;
        checks++; if (a_map !== 3'd1 || a_tpv !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL fva_force: got map %0d tpv %0b busy %0b expected 1 0 1", a_map, a_tpv, a_busy); end
        checks++; if (b_map !== 2'd1 || b_tpv !== 1'b0) begin errors++; $display("FAIL fva_force_b: got map %0d tpv %0b expected 1 0", b_map, b_tpv); end
        loc_x = 8'h7C;
        step();
        checks++; if (a_map !== 3'd1 || a_busy !== 1'b1 || a_tpv !== 1'b0) begin errors++; $display("FAIL fva_rearm: got map %0d busy %0b tpv %0b expected 1 1 0", a_map, a_busy, a_tpv); end
    endtask

    task automatic test_reset_mid_tp();
        loc_x = 8'h40;
        step();
        loc_x = 8'h7C;
        step();
        checks++; if (a_map !== 3'd2 || a_tpv !== 1'b1) begin errors++; $display("FAIL rmt_setup: got map %0d tpv %0b expected 2 1", a_map, a_tpv); end
        reset = 1'b0;
        #1;
        checks++; if (a_tpv !== 1'b0 || a_map !== 3'd0 || b_map !== 2'd0) begin errors++; $display("FAIL rmt_async: got tpv %0b a %0d b %0d expected 0 0 0", a_tpv, a_map, b_map); end
        checks++; if (a_wm !== 2'b00 || a_busy !== 1'b1) begin errors++; $display("FAIL rmt_async_out: got wm %0b busy %0b expected 00 1", a_wm, a_busy); end
        step();
        reset = 1'b1;
        repeat (3) step();
        checks++; if (a_busy !== 1'b1 || a_map !== 3'd0 || a_tpv !== 1'b0) begin errors++; $display("FAIL rmt_stay_rearm: got busy %0b map %0d tpv %0b expected 1 0 0", a_busy, a_map, a_tpv); end
        loc_x = 8'h40;
        step();
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rmt_play: got %0b expected 0", a_busy); end
        loc_x = 8'h7C;
        step();
        checks++; if (a_map !== 3'd1 || a_tpv !== 1'b1 || a_tpx !== 8'h01) begin errors++; $display("FAIL rmt_switch: got map %0d tpv %0b tpx %0h expected 1 1 01", a_map, a_tpv, a_tpx); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_backward_wrap();
        test_force();
        test_force_vs_ack();
        test_reset_mid_tp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
